mac_fix: RTL and testbench

Fixed-point multiply-accumulate neuron stage that consumes the product stream from the `w`-bit signed fixed-point multiplier and reduces one neuron's dot product. Products are in Q1.(W-1) format, i.e. the multiplier output already rescaled to W bits. The block loads a bias and accumulates exactly N products in a widened accumulator. It then applies optional ReLU, saturates to W bits, and presents the result to the next layer over a valid/ready handshake. One instance serves one neuron of a fully connected MNIST layer.

---
 rtl/mac_fix.sv | 115 +++++++++++
 tb/tb_mac_fix.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_fix.sv
// Fixed-point multiply-accumulate neuron stage: bias + N Q1.(W-1) products in a
// widened accumulator, optional ReLU, saturation to W bits, valid/ready output.
module mac_fix #(
   parameter int W    = 16,
   parameter int N    = 784,
   parameter int RELU = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] bias,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] prod,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int AW = W + $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_e;

   state_e               state_q, state_d;
   logic signed [AW-1:0] acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic                 busy_q, busy_d;
   logic                 accept;
   logic signed [AW-1:0] relu_v;

   assign accept = in_ready_q && in_valid;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d      = {{(AW-W){bias[W-1]}}, bias};
               cnt_d      = '0;
               state_d    = S_ACC;
               in_ready_d = 1'b1;
               busy_d     = 1'b1;
            end
         end
         S_ACC: begin
            if (accept) begin
               acc_d = acc_q + {{(AW-W){prod[W-1]}}, prod};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  state_d     = S_DONE;
                  in_ready_d  = 1'b0;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   // Result fits in W bits exactly when all bits from the W-1 sign position up agree.
   always_comb begin
      relu_v = ((RELU != 0) && acc_q[AW-1]) ? '0 : acc_q;
      if ((&relu_v[AW-1:W-1]) || (~|relu_v[AW-1:W-1]))
         out_data = relu_v[W-1:0];
      else if (relu_v[AW-1])
         out_data = {1'b1, {(W-1){1'b0}}};
      else
         out_data = {1'b0, {(W-1){1'b1}}};
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mac_fix.sv
// Directed bench for mac_fix: W=8 N=4 with and without ReLU, plus an N=1 instance,
// all sharing one stimulus bus.
module tb_mac_fix;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [7:0] bias = '0;
   logic       in_valid = 1'b0;
   logic [7:0] prod = '0;
   logic       out_ready = 1'b0;

   logic       a_in_ready, a_out_valid, a_busy;
   logic [7:0] a_out_data;
   logic       b_in_ready, b_out_valid, b_busy;
   logic [7:0] b_out_data;
   logic       c_in_ready, c_out_valid, c_busy;
   logic [7:0] c_out_data;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mac_fix #(.W(8), .N(4), .RELU(1)) u_relu (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
      .in_ready(a_in_ready), .prod(prod), .out_valid(a_out_valid),
      .out_ready(out_ready), .out_data(a_out_data), .busy(a_busy));

   mac_fix #(.W(8), .N(4), .RELU(0)) u_lin (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
      .in_ready(b_in_ready), .prod(prod), .out_valid(b_out_valid),
      .out_ready(out_ready), .out_data(b_out_data), .busy(b_busy));

   mac_fix #(.W(8), .N(1), .RELU(1)) u_n1 (
      .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid),
      .in_ready(c_in_ready), .prod(prod), .out_valid(c_out_valid),
      .out_ready(out_ready), .out_data(c_out_data), .busy(c_busy));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic go(input logic [7:0] b);
      start = 1'b1; bias = b;
      step();
      start = 1'b0;
   endtask

   task automatic feed4(input logic [7:0] p);
      in_valid = 1'b1; prod = p;
      repeat (4) step();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_chk++; if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", a_in_ready); else n_pass++;
      n_chk++; if (a_out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", a_out_valid); else n_pass++;
      n_chk++; if (a_busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", a_busy); else n_pass++;
      n_chk++; if (a_out_data !== 8'h00) $display("FAIL rst_out_data got %h exp 00", a_out_data); else n_pass++;
      n_chk++; if (b_out_data !== 8'h00) $display("FAIL rst_out_data_lin got %h exp 00", b_out_data); else n_pass++;
   endtask

   task automatic test_basic();
      int rdy;
      do_reset();
      go(8'h00);
      n_chk++; if (a_busy !== 1'b1) $display("FAIL basic_busy got %b exp 1", a_busy); else n_pass++;
      rdy = 0;
      in_valid = 1'b1; prod = 8'h10;
      for (int unsigned i = 0; i < 6; i++) begin
         if (a_in_ready) rdy++;
         if (i == 3) begin
            n_chk++; if (a_out_valid !== 1'b0) $display("FAIL basic_early_valid got %b exp 0", a_out_valid); else n_pass++;
         end
         if (i == 4) begin
            n_chk++; if (a_out_valid !== 1'b1) $display("FAIL basic_latency got %b exp 1", a_out_valid); else n_pass++;
         end
         step();
      end
      in_valid = 1'b0;
      n_chk++; if (rdy !== 4) $display("FAIL basic_ready_cycles got %0d exp 4", rdy); else n_pass++;
      n_chk++; if (a_out_data !== 8'h40) $display("FAIL basic_data got %h exp 40", a_out_data); else n_pass++;
      n_chk++; if (b_out_data !== 8'h40) $display("FAIL basic_data_lin got %h exp 40", b_out_data); else n_pass++;
      drain();
      n_chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) $display("FAIL basic_idle got valid=%b busy=%b exp 0 0", a_out_valid, a_busy); else n_pass++;
   endtask

   task automatic test_saturation();
      do_reset();
      go(8'h80);
      feed4(8'h80);
      n_chk++; if (b_out_data !== 8'h80) $display("FAIL sat_neg got %h exp 80", b_out_data); else n_pass++;
      n_chk++; if (a_out_data !== 8'h00) $display("FAIL sat_neg_relu got %h exp 00", a_out_data); else n_pass++;
      drain();
      go(8'h7F);
      feed4(8'h7F);
      n_chk++; if (b_out_data !== 8'h7F) $display("FAIL sat_pos got %h exp 7f", b_out_data); else n_pass++;
      n_chk++; if (a_out_data !== 8'h7F) $display("FAIL sat_pos_relu got %h exp 7f", a_out_data); else n_pass++;
      drain();
   endtask

   task automatic test_relu();
      do_reset();
      go(8'h00);
      feed4(8'hF0);
      n_chk++; if (a_out_data !== 8'h00) $display("FAIL relu_clamp got %h exp 00", a_out_data); else n_pass++;
      n_chk++; if (b_out_data !== 8'hC0) $display("FAIL relu_off got %h exp c0", b_out_data); else n_pass++;
      drain();
   endtask

   task automatic test_gaps();
      logic [6:0] pat;
      int acc_n;
      pat = 7'b1011001;
      acc_n = 0;
      do_reset();
      go(8'h00);
      for (int unsigned i = 0; i < 7; i++) begin
         in_valid = pat[i];
         prod = pat[i] ? 8'h10 : 8'h7F;
         if (in_valid && a_in_ready) acc_n++;
         step();
      end
      in_valid = 1'b0;
      n_chk++; if (acc_n !== 4) $display("FAIL gaps_accepts got %0d exp 4", acc_n); else n_pass++;
      n_chk++; if (a_out_valid !== 1'b1) $display("FAIL gaps_valid got %b exp 1", a_out_valid); else n_pass++;
      n_chk++; if (a_out_data !== 8'h40) $display("FAIL gaps_data got %h exp 40", a_out_data); else n_pass++;
      drain();
   endtask

   task automatic test_hold();
      do_reset();
      go(8'h00);
      feed4(8'h10);
      for (int unsigned i = 0; i < 3; i++) begin
         step();
         n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h40)
            $display("FAIL hold_stable got valid=%b data=%h exp 1 40", a_out_valid, a_out_data); else n_pass++;
      end
      drain();
      n_chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) $display("FAIL hold_release got valid=%b busy=%b exp 0 0", a_out_valid, a_busy); else n_pass++;
   endtask

   task automatic test_start_ignored();
      do_reset();
      go(8'h00);
      in_valid = 1'b1; prod = 8'h10;
      step(); step();
      start = 1'b1; bias = 8'h7F;
      step();
      start = 1'b0;
      step();
      in_valid = 1'b0;
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h40)
         $display("FAIL start_acc got valid=%b data=%h exp 1 40", a_out_valid, a_out_data); else n_pass++;
      start = 1'b1; bias = 8'h50;
      step();
      start = 1'b0;
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h40 || a_in_ready !== 1'b0)
         $display("FAIL start_done got valid=%b data=%h rdy=%b exp 1 40 0", a_out_valid, a_out_data, a_in_ready); else n_pass++;
      drain();
   endtask

   task automatic test_reset_mid();
      do_reset();
      go(8'h00);
      in_valid = 1'b1; prod = 8'h10;
      step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      n_chk++; if (a_in_ready !== 1'b0 || a_busy !== 1'b0 || a_out_valid !== 1'b0)
         $display("FAIL midrst_state got rdy=%b busy=%b valid=%b exp 0 0 0", a_in_ready, a_busy, a_out_valid); else n_pass++;
      go(8'h08);
      feed4(8'h08);
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h28)
         $display("FAIL midrst_fresh got valid=%b data=%h exp 1 28", a_out_valid, a_out_data); else n_pass++;
      drain();
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b1;
      go(8'h00);
      feed4(8'h10);
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h40)
         $display("FAIL b2b_first got valid=%b data=%h exp 1 40", a_out_valid, a_out_data); else n_pass++;
      step();
      n_chk++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0)
         $display("FAIL b2b_handshake got valid=%b busy=%b exp 0 0", a_out_valid, a_busy); else n_pass++;
      go(8'h01);
      n_chk++; if (a_in_ready !== 1'b1) $display("FAIL b2b_restart got %b exp 1", a_in_ready); else n_pass++;
      feed4(8'h04);
      n_chk++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h11)
         $display("FAIL b2b_second got valid=%b data=%h exp 1 11", a_out_valid, a_out_data); else n_pass++;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_n1();
      do_reset();
      go(8'h10);
      n_chk++; if (c_in_ready !== 1'b1) $display("FAIL n1_ready got %b exp 1", c_in_ready); else n_pass++;
      in_valid = 1'b1; prod = 8'h20;
      step();
      in_valid = 1'b0;
      n_chk++; if (c_out_valid !== 1'b1 || c_out_data !== 8'h30 || c_in_ready !== 1'b0)
         $display("FAIL n1_result got valid=%b data=%h rdy=%b exp 1 30 0", c_out_valid, c_out_data, c_in_ready); else n_pass++;
      drain();
   endtask

   initial begin
      step();
      test_reset();
      test_basic();
      test_saturation();
      test_relu();
      test_gaps();
      test_hold();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_n1();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
